spi_txn_scheduler: RTL and testbench

- Round-robin scheduler that shares one SPI master datapath between NUM_REQ requesters.
- Per transaction: grants one requester, latches its mode (cpol/cpha) and tx word, then drives the 2-bit phase state consumed by the chip-select controller and shift engine.
- Handshakes with the CS controller (start_transfer) and the shift engine (xfer_done); returns rx data and a per-requester done/err pulse.

---
 rtl/spi_txn_scheduler.sv | 142 ++++++++++++++
 tb/tb_spi_txn_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler
// Round-robin owner of a shared SPI master datapath. Each transaction grants
// one requester and latches its mode bits and tx word. It then walks the
// IDLE -> SETUP -> TRANSFER -> DONE phases that drive the chip-select
// controller and the shift engine.
module spi_txn_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 8,
    parameter int SETUP_TIMEOUT = 15,
    parameter int HOLD_CYC      = 2
) (
    input  logic                      prescale_clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_cpol,
    input  logic [NUM_REQ-1:0]        req_cpha,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      start_transfer,
    input  logic                      xfer_done,
    input  logic [DATA_W-1:0]         rx_shift,
    output logic [1:0]                state,
    output logic                      cpol,
    output logic                      cpha,
    output logic [DATA_W-1:0]         tx_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [NUM_REQ-1:0]        err,
    output logic [DATA_W-1:0]         rx_data
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int MAX_CNT = (SETUP_TIMEOUT > HOLD_CYC) ? SETUP_TIMEOUT : HOLD_CYC;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    // Terminal counts: the counter starts at 0 on phase entry, so the last
    // cycle of a phase lasting N cycles sees N-1.
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_SETUP    = 2'b01,
        ST_TRANSFER = 2'b10,
        ST_DONE     = 2'b11
    } phase_t;

    phase_t           phase;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;

    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    logic [IDX_W-1:0] arb_cand;

    assign state = phase;

    // Pick the first active request at or above the round-robin pointer, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before any conditional assignment, so no latch is inferred.
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!arb_found && req[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    // Transaction phase machine with registered grant, config, pulses and rx word.
    always_ff @(posedge prescale_clk or posedge rst) begin
        if (rst) begin
            phase   <= ST_IDLE;
            cnt     <= '0;
            rr_ptr  <= '0;
            owner   <= '0;
            grant   <= '0;
            done    <= '0;
            err     <= '0;
            cpol    <= 1'b0;
            cpha    <= 1'b0;
            tx_data <= '0;
            rx_data <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads pre-edge values.
            // done/err are cleared every edge and set only on DONE entry, giving a one-cycle pulse.
            done <= '0;
            err  <= '0;
            case (phase)
                ST_IDLE: begin
                    if (arb_found) begin
                        grant   <= NUM_REQ'(1) << arb_idx;
                        owner   <= arb_idx;
                        cpol    <= req_cpol[arb_idx];
                        cpha    <= req_cpha[arb_idx];
                        tx_data <= req_data[int'(arb_idx)*DATA_W +: DATA_W];
                        cnt     <= '0;
                        phase   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    // start_transfer has priority over a timeout on the same edge.
                    if (start_transfer) begin
                        cnt   <= '0;
                        phase <= ST_TRANSFER;
                    end else if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        err   <= grant;
                        phase <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_TRANSFER: begin
                    // The shift engine is trusted to finish, so there is no timeout here.
                    if (xfer_done) begin
                        rx_data <= rx_shift;
                        done    <= grant;
                        cnt     <= '0;
                        phase   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (cnt == HOLD_LAST) begin
                        cnt    <= '0;
                        grant  <= '0;
                        rr_ptr <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
                        phase  <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: phase <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// tb_spi_txn_scheduler
// Drives whole transactions and compares each cycle's outputs against a
// per-transaction expected trace. The trace is built from the phase timing
// rules: the grant choice, the SETUP/TRANSFER/DONE lengths, the pulses and
// the rx hold.
module tb_spi_txn_scheduler;

    localparam int NUM_REQ       = 4;
    localparam int DATA_W        = 8;
    localparam int SETUP_TIMEOUT = 15;
    localparam int HOLD_CYC      = 2;

    logic                      prescale_clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_cpol;
    logic [NUM_REQ-1:0]        req_cpha;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      start_transfer;
    logic                      xfer_done;
    logic [DATA_W-1:0]         rx_shift;
    logic [1:0]                state;
    logic                      cpol;
    logic                      cpha;
    logic [DATA_W-1:0]         tx_data;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic [NUM_REQ-1:0]        err;
    logic [DATA_W-1:0]         rx_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: round-robin pointer and last received word.
    int                m_rr = 0;
    logic [DATA_W-1:0] m_rx = '0;

    typedef struct packed {
        logic [1:0]         st;
        logic [NUM_REQ-1:0] gr;
        logic [NUM_REQ-1:0] dn;
        logic [NUM_REQ-1:0] er;
        logic [DATA_W-1:0]  rx;
    } core_t;

    typedef struct packed {
        logic              cp;
        logic              ch;
        logic [DATA_W-1:0] tx;
    } cfg_t;

    spi_txn_scheduler #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W),
        .SETUP_TIMEOUT(SETUP_TIMEOUT), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .prescale_clk  (prescale_clk),
        .rst           (rst),
        .req           (req),
        .req_cpol      (req_cpol),
        .req_cpha      (req_cpha),
        .req_data      (req_data),
        .start_transfer(start_transfer),
        .xfer_done     (xfer_done),
        .rx_shift      (rx_shift),
        .state         (state),
        .cpol          (cpol),
        .cpha          (cpha),
        .tx_data       (tx_data),
        .grant         (grant),
        .done          (done),
        .err           (err),
        .rx_data       (rx_data)
    );

    initial prescale_clk = 1'b0;
    always #5 prescale_clk = ~prescale_clk;

    function automatic core_t mk_core(input logic [1:0] st, input logic [NUM_REQ-1:0] gr,
                                      input logic [NUM_REQ-1:0] dn, input logic [NUM_REQ-1:0] er,
                                      input logic [DATA_W-1:0] rx);
        core_t r;
        r.st = st; r.gr = gr; r.dn = dn; r.er = er; r.rx = rx;
        return r;
    endfunction

    function automatic core_t obs_core();
        return mk_core(state, grant, done, err, rx_data);
    endfunction

    function automatic cfg_t obs_cfg();
        cfg_t r;
        r.cp = cpol; r.ch = cpha; r.tx = tx_data;
        return r;
    endfunction

    // Round-robin choice: first set request at rr, rr+1, ... modulo NUM_REQ.
    function automatic int model_pick(input logic [NUM_REQ-1:0] r, input int rr);
        for (int k = 0; k < NUM_REQ; k++)
            if (r[(rr + k) % NUM_REQ]) return (rr + k) % NUM_REQ;
        return 0;
    endfunction

    // One full transaction from request to the IDLE cycle after DONE.
    // st_dly: SETUP cycles with start_transfer low before it is raised (<0 = never).
    // xf_dly: TRANSFER cycles with xfer_done low before it pulses.
    // scr: 0 leave config inputs alone, 1 randomise them, 2 drive them all-ones while granted.
    task automatic run_txn(input string name, input logic [NUM_REQ-1:0] reqv,
                           input logic [NUM_REQ-1:0] cpolv, input logic [NUM_REQ-1:0] cphav,
                           input logic [NUM_REQ*DATA_W-1:0] datav,
                           input int st_dly, input int xf_dly, input logic [DATA_W-1:0] rxv,
                           input bit xf_in_setup, input bit drop_req, input bit keep_req, input int scr);
        int                 idx;
        int                 n_setup;
        int                 n_xfer;
        int                 len;
        bit                 abort;
        logic [NUM_REQ-1:0] oh;
        core_t              exp_core[$];
        bit                 exp_cfg_on[$];
        cfg_t               exp_cfg;
        core_t              oc;
        cfg_t               ocfg;

        idx     = model_pick(reqv, m_rr);
        oh      = '0;
        oh[idx] = 1'b1;
        abort   = (st_dly < 0) || (st_dly >= SETUP_TIMEOUT);
        n_setup = abort ? SETUP_TIMEOUT : st_dly + 1;
        n_xfer  = abort ? 0 : xf_dly + 1;
        exp_cfg.cp = cpolv[idx];
        exp_cfg.ch = cphav[idx];
        exp_cfg.tx = datav[idx*DATA_W +: DATA_W];

        for (int c = 0; c < n_setup; c++) begin
            exp_core.push_back(mk_core(2'b01, oh, '0, '0, m_rx));
            exp_cfg_on.push_back(1'b1);
        end
        for (int c = 0; c < n_xfer; c++) begin
            exp_core.push_back(mk_core(2'b10, oh, '0, '0, m_rx));
            exp_cfg_on.push_back(1'b1);
        end
        if (!abort) m_rx = rxv;
        for (int h = 0; h < HOLD_CYC; h++) begin
            exp_core.push_back(mk_core(2'b11, oh, (h == 0 && !abort) ? oh : '0,
                                       (h == 0 && abort) ? oh : '0, m_rx));
            exp_cfg_on.push_back(1'b1);
        end
        exp_core.push_back(mk_core(2'b00, '0, '0, '0, m_rx));
        exp_cfg_on.push_back(1'b0);
        m_rr = (idx + 1) % NUM_REQ;

        req      = reqv;
        req_cpol = cpolv;
        req_cpha = cphav;
        req_data = datav;
        len      = exp_core.size();
        for (int c = 0; c < len; c++) begin
            @(negedge prescale_clk);
            start_transfer = 1'b0;
            xfer_done      = 1'b0;
            oc = obs_core();
            n_checks++;
            if (oc !== exp_core[c]) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got state=%b grant=%b done=%b err=%b rx=%h, expected state=%b grant=%b done=%b err=%b rx=%h",
                         name, c, oc.st, oc.gr, oc.dn, oc.er, oc.rx,
                         exp_core[c].st, exp_core[c].gr, exp_core[c].dn, exp_core[c].er, exp_core[c].rx);
            end
            if (exp_cfg_on[c]) begin
                ocfg = obs_cfg();
                n_checks++;
                if (ocfg !== exp_cfg) begin
                    n_fail++;
                    $display("FAIL %s cfg cycle %0d: got cpol=%b cpha=%b tx=%h, expected cpol=%b cpha=%b tx=%h",
                             name, c, ocfg.cp, ocfg.ch, ocfg.tx, exp_cfg.cp, exp_cfg.ch, exp_cfg.tx);
                end
            end
            // Stimulus for the next rising edge.
            if (c == 0 && drop_req) req = '0;
            if (scr == 1) begin
                req_cpol = NUM_REQ'($urandom);
                req_cpha = NUM_REQ'($urandom);
                req_data = (NUM_REQ*DATA_W)'($urandom);
            end else if (scr == 2) begin
                req_cpol = '1;
                req_cpha = '1;
                req_data = '1;
            end
            if (!abort && c == st_dly) start_transfer = 1'b1;
            if (xf_in_setup && c == 0) begin
                xfer_done = 1'b1;
                rx_shift  = ~rxv;
            end
            if (!abort && c == n_setup + xf_dly) begin
                xfer_done = 1'b1;
                rx_shift  = rxv;
            end
            if (c == len - 1 && !keep_req) req = '0;
        end
    endtask

    task automatic check_all_zero(input string name);
        core_t oc;
        cfg_t  ocfg;
        oc   = obs_core();
        ocfg = obs_cfg();
        n_checks++;
        if (oc !== mk_core(2'b00, '0, '0, '0, '0) || ocfg !== '0) begin
            n_fail++;
            $display("FAIL %s: got state=%b grant=%b done=%b err=%b rx=%h cpol=%b cpha=%b tx=%h, expected all zero",
                     name, oc.st, oc.gr, oc.dn, oc.er, oc.rx, ocfg.cp, ocfg.ch, ocfg.tx);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        check_all_zero("reset");
        @(negedge prescale_clk);
        @(negedge prescale_clk);
        rst  = 1'b0;
        m_rr = 0;
        m_rx = '0;
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_0", 4'b0101, 4'b0100, 4'b0001, 32'h00C3_005A, 1, 2, 8'h11, 1'b0, 1'b0, 1'b1, 0);
        run_txn("b2b_1", 4'b0101, 4'b0100, 4'b0001, 32'h00C3_005A, 0, 0, 8'h22, 1'b0, 1'b0, 1'b1, 0);
        run_txn("b2b_2", 4'b0101, 4'b0100, 4'b0001, 32'h00C3_005A, 2, 1, 8'h33, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_basic();
        run_txn("basic", 4'b0001, 4'b0001, 4'b0001, 32'h0000_00A5, 3, 7, 8'h3C, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_timeout();
        run_txn("timeout", 4'b0010, 4'b0010, 4'b0000, 32'h0000_7700, -1, 0, 8'hEE, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_config_hold();
        run_txn("cfg_hold", 4'b0100, 4'b0000, 4'b0000, 32'h0011_0000, 2, 4, 8'h5D, 1'b0, 1'b0, 1'b0, 2);
    endtask

    task automatic test_withdraw();
        run_txn("withdraw", 4'b1000, 4'b1000, 4'b0000, 32'h9600_0000, 1, 3, 8'h4B, 1'b0, 1'b1, 1'b0, 1);
    endtask

    task automatic test_ignore_and_priority();
        run_txn("start_wins", 4'b0001, 4'b0000, 4'b0001, 32'h0000_0042, SETUP_TIMEOUT - 1, 1, 8'h81,
                1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            logic [NUM_REQ-1:0] r;
            int                 sd;
            r  = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            sd = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, SETUP_TIMEOUT + 2));
            run_txn($sformatf("rand_%0d", t), r, NUM_REQ'($urandom), NUM_REQ'($urandom),
                    (NUM_REQ*DATA_W)'($urandom), sd, int'($urandom_range(0, 10)), DATA_W'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 1);
        end
    endtask

    task automatic test_reset_mid();
        // Finish a transaction on requester 1 so the pointer sits at 2.
        run_txn("rm_pre", 4'b0010, 4'b0000, 4'b0000, 32'h0000_1200, 1, 1, 8'h77, 1'b0, 1'b0, 1'b0, 0);
        req      = 4'b0100;
        req_cpol = 4'b0100;
        req_cpha = 4'b0100;
        req_data = 32'h00AB_0000;
        @(negedge prescale_clk);
        start_transfer = 1'b1;
        @(negedge prescale_clk);
        start_transfer = 1'b0;
        n_checks++;
        if (state !== 2'b10 || grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL rm_enter: got state=%b grant=%b, expected state=10 grant=0100", state, grant);
        end
        #2 rst = 1'b1;
        #1 check_all_zero("rm_async");
        xfer_done = 1'b1;
        rx_shift  = 8'hDD;
        @(negedge prescale_clk);
        xfer_done = 1'b0;
        check_all_zero("rm_held");
        rst  = 1'b0;
        m_rr = 0;
        m_rx = '0;
        run_txn("rm_ptr0", 4'b1111, 4'b0101, 4'b0011, 32'h4433_2211, 0, 2, 8'h19, 1'b0, 1'b0, 1'b0, 0);
        run_txn("rm_1000", 4'b1000, 4'b1000, 4'b0000, 32'h8800_0000, 1, 1, 8'h2A, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        req            = '0;
        req_cpol       = '0;
        req_cpha       = '0;
        req_data       = '0;
        start_transfer = 1'b0;
        xfer_done      = 1'b0;
        rx_shift       = '0;
        rst            = 1'b0;

        test_reset();
        test_back_to_back();
        test_basic();
        test_timeout();
        test_config_hold();
        test_withdraw();
        test_ignore_and_priority();
        test_random();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "time limit");
    end

endmodule
